golden_checker: RTL

GOLDEN_CHECKER -- requirements
Module: golden_checker

---
 rtl/golden_pkg.sv | 52 +++++
 rtl/golden_fifo.sv | 55 +++++
 rtl/golden_checker.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/golden_pkg.sv
// Shared definitions for the golden checker: register map, width codes,
// the expected-result entry layout and the expected-value helper functions.
package golden_pkg;

  // Register select, taken from paddr[3:2]
  localparam logic [1:0] REG_CTRL    = 2'b00;
  localparam logic [1:0] REG_DATA_IN = 2'b01;
  localparam logic [1:0] REG_CW      = 2'b10;
  localparam logic [1:0] REG_NOISE   = 2'b11;

  // Codeword width codes (CODEWORD_WIDTH[1:0]); 2'b11 also means 32 bits
  localparam logic [1:0] WC_8  = 2'b00;
  localparam logic [1:0] WC_16 = 2'b01;
  localparam logic [1:0] WC_32 = 2'b10;

  // One pending expectation. Data is always held at the widest legal bus
  // width so the entry layout does not depend on the checker parameters.
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  nof;
    logic [1:0]  wcode;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  // Bit mask covering the codeword width, clamped to the bus width aw.
  function automatic logic [31:0] width_mask(input logic [1:0] wcode, input int aw);
    int w;
    case (wcode)
      WC_8:    w = 8;
      WC_16:   w = 16;
      default: w = 32;
    endcase
    if (w > aw) w = aw;
    if (w >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << w) - 32'd1;
  endfunction

  // Expected error count: encode ops report none; decode ops classify the
  // in-width noise as clean (00), single/odd (01) or even nonzero (10).
  function automatic logic [1:0] calc_nof(input logic [1:0] op,
                                          input logic [31:0] noise,
                                          input logic [31:0] mask);
    logic [31:0] m;
    m = noise & mask;
    if (op == 2'b00) return 2'b00;
    if (m == 32'd0)  return 2'b00;
    if (^m)          return 2'b01;
    return 2'b10;
  endfunction

endpackage

// File: rtl/golden_fifo.sv
// Synchronous FIFO with occupancy count. Writes while full are ignored unless
// a read happens on the same edge; reads while empty are ignored.
module golden_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_wr, do_rd;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem_q[rptr_q];
  assign count   = count_q;

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= wr_data;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + PW'(1);
      if (do_rd) rptr_q <= rptr_q + PW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/golden_checker.sv
// Golden checker: shadows the DUT's register writes, queues the expected
// result of every CTRL write and compares it against the DUT output on each
// rising edge of operation_done.
module golden_checker
  import golden_pkg::*;
#(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int DEPTH           = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AMBA_ADDR_WIDTH-1:0] paddr,
  input  logic [AMBA_WORD-1:0]       pwdata,
  input  logic                       reg_wr,
  input  logic                       reg_rd,
  input  logic [AMBA_WORD-1:0]       full_word,
  input  logic                       operation_done,
  input  logic [AMBA_WORD-1:0]       dut_data_out,
  input  logic [1:0]                 dut_num_of_errors,
  output logic [AMBA_WORD-1:0]       prdata,
  output logic [AMBA_WORD-1:0]       exp_data_out,
  output logic [1:0]                 exp_num_of_errors,
  output logic                       chk_valid,
  output logic                       chk_mismatch,
  output logic [15:0]                check_cnt,
  output logic [15:0]                mismatch_cnt,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  output logic                       underflow
);

  // Shadow registers and the captured expected word
  logic [AMBA_WORD-1:0] ctrl_q, din_q, cw_q, noise_q, word_q;
  logic [AMBA_WORD-1:0] prdata_q;
  logic [1:0]           sel;

  // Push side
  logic        push;
  logic [31:0] push_mask;
  entry_t      push_entry;

  // Pop side
  logic        done_q, done_rise, pop;
  logic        fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_rd_data;
  entry_t      ent_q;

  // Compare pipeline: bit 0 = entry popped, bit 1 = check result valid
  logic [1:0]  vld_pipe_q;
  logic [31:0] cmp_mask;
  logic        cmp_mis;
  logic        mis_q;
  logic [AMBA_WORD-1:0] exp_data_q;
  logic [1:0]  exp_nof_q;
  logic [15:0] check_cnt_q, mismatch_cnt_q;
  logic        ovf_q, unf_q;

  logic unused_addr;
  assign unused_addr = ^{paddr[AMBA_ADDR_WIDTH-1:4], paddr[1:0]};

  assign sel = paddr[3:2];

  // Entry built from post-write state: CTRL comes from pwdata this cycle,
  // the other registers are unchanged because only CTRL is being written.
  assign push      = reg_wr & (sel == REG_CTRL);
  assign push_mask = width_mask(cw_q[1:0], AMBA_WORD);
  always_comb begin
    push_entry       = '0;
    push_entry.wcode = cw_q[1:0];
    push_entry.data  = 32'(word_q) & push_mask;
    push_entry.nof   = calc_nof(pwdata[1:0], 32'(noise_q), push_mask);
  end

  assign done_rise = operation_done & ~done_q;
  assign pop       = done_rise & ~fifo_empty;

  golden_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (push_entry),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Compare the registered entry against the DUT result on the following cycle
  assign cmp_mask = width_mask(ent_q.wcode, AMBA_WORD);
  assign cmp_mis  = ((dut_data_out & cmp_mask[AMBA_WORD-1:0]) != ent_q.data[AMBA_WORD-1:0]) |
                    (dut_num_of_errors != ent_q.nof);

  // Shadow register file writes and expected-word capture
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      din_q   <= '0;
      cw_q    <= '0;
      noise_q <= '0;
      word_q  <= '0;
    end else if (reg_wr) begin
      case (sel)
        REG_CTRL:    ctrl_q  <= pwdata;
        REG_DATA_IN: begin
          din_q  <= pwdata;
          word_q <= full_word;
        end
        REG_CW:      cw_q    <= pwdata;
        default:     noise_q <= pwdata;
      endcase
    end
  end

  // Register read port: one-cycle latency, holds between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      prdata_q <= '0;
    end else if (reg_rd) begin
      case (sel)
        REG_CTRL:    prdata_q <= ctrl_q;
        REG_DATA_IN: prdata_q <= din_q;
        REG_CW:      prdata_q <= cw_q;
        default:     prdata_q <= noise_q;
      endcase
    end
  end

  // Previous done level; during reset it tracks the input so a level that is
  // already high when reset releases is not mistaken for a new edge.
  always_ff @(posedge clk) begin
    if (rst) done_q <= operation_done;
    else     done_q <= operation_done;
  end

  // Sticky overflow (push dropped) and underflow (done with nothing queued)
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (push & fifo_full & ~pop) ovf_q <= 1'b1;
      if (done_rise & fifo_empty)  unf_q <= 1'b1;
    end
  end

  // Pop capture, compare, expected-value outputs and saturating counters
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q     <= '0;
      ent_q          <= '0;
      mis_q          <= 1'b0;
      exp_data_q     <= '0;
      exp_nof_q      <= '0;
      check_cnt_q    <= '0;
      mismatch_cnt_q <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], pop};
      if (pop) ent_q <= fifo_rd_data;
      mis_q <= vld_pipe_q[0] & cmp_mis;
      if (vld_pipe_q[0]) begin
        exp_data_q <= ent_q.data[AMBA_WORD-1:0];
        exp_nof_q  <= ent_q.nof;
        if (check_cnt_q != 16'hFFFF) check_cnt_q <= check_cnt_q + 16'd1;
        if (cmp_mis && mismatch_cnt_q != 16'hFFFF)
          mismatch_cnt_q <= mismatch_cnt_q + 16'd1;
      end
    end
  end

  assign prdata            = prdata_q;
  assign exp_data_out      = exp_data_q;
  assign exp_num_of_errors = exp_nof_q;
  assign chk_valid         = vld_pipe_q[1];
  assign chk_mismatch      = mis_q;
  assign check_cnt         = check_cnt_q;
  assign mismatch_cnt      = mismatch_cnt_q;
  assign overflow          = ovf_q;
  assign underflow         = unf_q;

endmodule
